result_demux8: RTL and testbench



---
 rtl/result_demux8_pkg.sv | 15 +
 rtl/dec3to8.sv | 15 +
 rtl/result_demux8.sv | 89 ++++++++
 tb/tb_result_demux8.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/result_demux8_pkg.sv
// Shared constants and types for the registered 1-to-8 result distributor.
package result_demux8_pkg;

    localparam int DW    = 32;
    localparam int SW    = 3;
    localparam int NDEST = 8;

    typedef logic [NDEST-1:0] pend_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder used to build the destination mask.
module dec3to8
    import result_demux8_pkg::*;
(
    input  logic [2:0] sel,
    output pend_t      onehot
);

    generate
        for (genvar gi = 0; gi < NDEST; gi++) begin : g_dec
            assign onehot[gi] = (sel == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/result_demux8.sv
// Registered 1-to-8 result distributor: holds one tagged word until every
// addressed destination has taken it. Broadcast is enabled by RESULT_DEMUX8_BCAST_EN.
module result_demux8
    import result_demux8_pkg::*;
#(
    parameter int DW = result_demux8_pkg::DW,
    parameter int SW = result_demux8_pkg::SW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     in_data,
    input  logic [SW-1:0]     in_sel,
    input  logic              in_bcast,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DW-1:0]     out_data,
    output logic [NDEST-1:0]  out_valid,
    input  logic [NDEST-1:0]  out_ready,
    output logic [15:0]       xfer_cnt
);

    pend_t         pend_reg;
    pend_t         pend_next;
    pend_t         sel_onehot;
    pend_t         load_mask;
    pend_t         remain;
    logic [DW-1:0] data_reg;
    logic [15:0]   cnt_reg;
    logic          accept;
    logic          retire;
    state_t        state;

    dec3to8 u_dec (
        .sel    (in_sel),
        .onehot (sel_onehot)
    );

`ifdef RESULT_DEMUX8_BCAST_EN
    assign load_mask = in_bcast ? '1 : sel_onehot;
`else
    logic unused_bcast;
    assign unused_bcast = in_bcast;
    assign load_mask    = sel_onehot;
`endif

    // Bits still owed after this edge; ready on a non-pending bit is masked out.
    assign remain   = pend_reg & ~out_ready;
    assign in_ready = (remain == '0);
    assign accept   = in_valid && in_ready;
    assign retire   = (pend_reg != '0) && (remain == '0);
    assign state    = (pend_reg == '0) ? EMPTY : HOLD;

    always_comb begin
        pend_next = remain;
        if (accept) begin
            pend_next = load_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= '0;
            data_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            pend_reg <= pend_next;
            if (accept) begin
                data_reg <= in_data;
            end
            if (retire) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign out_valid = pend_reg;
    assign out_data  = data_reg;
    assign xfer_cnt  = cnt_reg;

    // A held word must not change while any destination still owes an accept.
    a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state == HOLD && !in_ready) |=> $stable(data_reg));

`ifndef RESULT_DEMUX8_BCAST_EN
    a_pend_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(pend_reg));
`endif

endmodule

// File: tb/tb_result_demux8.sv
// Directed self-checking bench for result_demux8 (reset, single, back-to-back,
// stall, broadcast, counter wrap).
module tb_result_demux8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [2:0]  in_sel;
    logic        in_bcast;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [15:0] xfer_cnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_cnt;
    logic [7:0]  exp_pend;

    always #5 clk = ~clk;

    result_demux8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_bcast  = 1'b0;
        in_valid  = 1'b0;
        out_ready = '0;
        exp_cnt   = '0;
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_cnt", 32'(xfer_cnt), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        tick();
        tick();
        rst_n = 1'b1;

        // Single transfer to destination 5
        in_data = 32'hDEADBEEF; in_sel = 3'd5; in_valid = 1'b1; out_ready = 8'hFF;
        check("single_inrdy", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        $display("txn single: sel=5 data=%h out_valid=%h", out_data, out_valid);
        check("single_valid", 32'(out_valid), 32'h20);
        check("single_data", out_data, 32'hDEADBEEF);
        check("single_cnt0", 32'(xfer_cnt), 32'h0);
        tick();
        exp_cnt = 16'd1;
        check("single_done", 32'(out_valid), 32'h0);
        check("single_cnt", 32'(xfer_cnt), 32'(exp_cnt));

        // Back-to-back to destinations 0,1,2 with all ready
        for (int i = 0; i < 3; i++) begin
            in_sel = 3'(i); in_data = 32'h1000 + 32'(i); in_valid = 1'b1;
            check("b2b_inrdy", 32'(in_ready), 32'h1);
            tick();
            $display("txn b2b: sel=%0d data=%h out_valid=%h", i, out_data, out_valid);
            check("b2b_valid", 32'(out_valid), 32'h1 << i);
            check("b2b_data", out_data, 32'h1000 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        exp_cnt = exp_cnt + 16'd3;
        check("b2b_empty", 32'(out_valid), 32'h0);
        check("b2b_cnt", 32'(xfer_cnt), 32'(exp_cnt));

        // Stall: destination 3 withholds ready for 4 cycles
        out_ready = 8'hF7;
        in_sel = 3'd3; in_data = 32'h33333333; in_valid = 1'b1;
        tick();
        in_sel = 3'd1; in_data = 32'h44444444;
        for (int i = 0; i < 4; i++) begin
            $display("txn stall: cycle=%0d in_ready=%0d out_data=%h", i, in_ready, out_data);
            check("stall_inrdy", 32'(in_ready), 32'h0);
            check("stall_data", out_data, 32'h33333333);
            check("stall_valid", 32'(out_valid), 32'h08);
            tick();
        end
        out_ready = 8'hFF;
        #1;
        check("stall_release", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        $display("txn stall_next: sel=1 data=%h out_valid=%h", out_data, out_valid);
        check("stall_next_valid", 32'(out_valid), 32'h02);
        check("stall_next_data", out_data, 32'h44444444);
        check("stall_retire_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        tick();
        exp_cnt = exp_cnt + 16'd1;
        check("stall_next_cnt", 32'(xfer_cnt), 32'(exp_cnt));

        // Broadcast request (honoured only with the feature enabled)
        out_ready = 8'h00;
        in_data = 32'hB0B0CAFE; in_sel = 3'd2; in_bcast = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_bcast = 1'b0;
`ifdef RESULT_DEMUX8_BCAST_EN
        exp_pend = 8'hFF;
        check("bcast_valid", 32'(out_valid), 32'(exp_pend));
        for (int i = 0; i < 8; i++) begin
            out_ready = 8'h01 << i;
            #1;
            check("bcast_inrdy", 32'(in_ready), (i == 7) ? 32'h1 : 32'h0);
            tick();
            exp_pend = exp_pend & ~(8'h01 << i);
            if (i == 7) exp_cnt = exp_cnt + 16'd1;
            $display("txn bcast: ack=%0d out_valid=%h cnt=%0d", i, out_valid, xfer_cnt);
            check("bcast_pend", 32'(out_valid), 32'(exp_pend));
            check("bcast_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        end
`else
        $display("txn bcast_ignored: out_valid=%h", out_valid);
        check("nobcast_valid", 32'(out_valid), 32'h04);
        check("nobcast_data", out_data, 32'hB0B0CAFE);
        out_ready = 8'hFB;
        tick();
        check("nobcast_hold", 32'(out_valid), 32'h04);
        out_ready = 8'h04;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        check("nobcast_done", 32'(out_valid), 32'h0);
        check("nobcast_cnt", 32'(xfer_cnt), 32'(exp_cnt));
`endif

        // Asynchronous reset while holding a word for destination 2
        out_ready = 8'h00;
        in_sel = 3'd2; in_data = 32'h5A5A5A5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mid_hold", 32'(out_valid), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn reset_mid_hold: out_valid=%h out_data=%h cnt=%0d", out_valid, out_data, xfer_cnt);
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_data", out_data, 32'h0);
        check("arst_cnt", 32'(xfer_cnt), 32'h0);
        check("arst_ready", 32'(in_ready), 32'h1);
        tick();
        rst_n = 1'b1;

        // Counter wrap: 65535 retired words, then one more
        out_ready = 8'hFF; in_sel = 3'd0; in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_data = 32'(i);
            @(posedge clk);
        end
        #1;
        $display("txn wrap_preload: cnt=%h", xfer_cnt);
        check("wrap_pre", 32'(xfer_cnt), 32'hFFFF);
        in_valid = 1'b0;
        tick();
        $display("txn wrap: cnt=%h", xfer_cnt);
        check("wrap_cnt", 32'(xfer_cnt), 32'h0);
        check("wrap_empty", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
